// File: rtl/ofs_pcie_ss_cfg_pkg.sv
// PCIe SS datapath configuration shared by the FIM AXI-S blocks.
// Only the stream widths consumed by the packet buffer are reproduced here.
package ofs_pcie_ss_cfg_pkg;
  localparam int TDATA_WIDTH = 512;
  localparam int TUSER_WIDTH = 10;
endpackage

// File: rtl/ofs_fim_axis_pkt_buffer_ram.sv
// Simple dual-port beat RAM: one write port, one read port with a registered
// output that holds its value while rd_en is low. Contents are not reset.
module ofs_fim_axis_pkt_buffer_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ofs_fim_axis_pkt_buffer.sv
// Store-and-forward AXI-S packet buffer: a packet is only presented on the
// source side once its tlast beat is stored, except in oversize cut-through.
module ofs_fim_axis_pkt_buffer #(
  parameter int TDATA_WIDTH   = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
  parameter int TUSER_WIDTH   = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH,
  parameter int DEPTH_LOG2    = 6,
  parameter int MAX_PKTS_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic                     s_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic [TUSER_WIDTH-1:0]   m_tuser,
  output logic [DEPTH_LOG2:0]      fill_level,
  output logic [MAX_PKTS_LOG2:0]   pkt_count,
  output logic                     cut_through
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int BEAT_W = TDATA_WIDTH + KEEP_W + 1 + TUSER_WIDTH;
  localparam logic [DEPTH_LOG2:0]    FILL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [MAX_PKTS_LOG2:0] PKT_MAX  = {1'b1, {MAX_PKTS_LOG2{1'b0}}};

  // Handshake: a beat moves on a port at the rising edge where valid and ready
  // are both high; valid never waits on ready, and a raised m_tvalid holds
  // with m_* stable until it is taken. s_tready is a register.

  logic [DEPTH_LOG2:0]    wr_ptr, rd_ptr;
  logic                   q_valid, out_valid;
  logic [BEAT_W-1:0]      ram_rdata, out_beat;
  logic [MAX_PKTS_LOG2:0] rel_count;
  logic [1:0]             inc_pipe;

  logic                   accept, pop, ram_empty, rd_en, load_out;
  logic                   pkt_in, pkt_out;
  logic                   q_valid_next, out_valid_next, ct_next;
  logic [DEPTH_LOG2:0]    fill_next;
  logic [MAX_PKTS_LOG2:0] pkt_next, rel_next;

  assign accept    = s_tvalid & s_tready;
  assign pop       = m_tvalid & m_tready;
  assign ram_empty = (wr_ptr == rd_ptr);
  // Prefetch: output register refills from the RAM read register on a pop,
  // and the RAM is read whenever its read register is free or draining.
  assign load_out  = q_valid & (~out_valid | pop);
  assign rd_en     = ~ram_empty & (~q_valid | load_out);
  assign pkt_in    = accept & s_tlast;
  assign pkt_out   = pop & m_tlast;

  // rel_count trails pkt_count by two edges on increment, giving the release
  // point the same timing as the tlast beat reaching the output register.
  assign m_tvalid = out_valid & ((rel_count != '0) | cut_through);
  assign {m_tdata, m_tkeep, m_tlast, m_tuser} = out_beat;

  ofs_fim_axis_pkt_buffer_ram #(
    .WIDTH      (BEAT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data ({s_tdata, s_tkeep, s_tlast, s_tuser}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (ram_rdata)
  );

  always_comb begin
    fill_next      = fill_level;
    pkt_next       = pkt_count;
    rel_next       = rel_count;
    ct_next        = cut_through;
    q_valid_next   = q_valid;
    out_valid_next = out_valid;

    if (accept && !pop)      fill_next = fill_level + 1'b1;
    else if (!accept && pop) fill_next = fill_level - 1'b1;

    if (pkt_in && !pkt_out)      pkt_next = pkt_count + 1'b1;
    else if (!pkt_in && pkt_out) pkt_next = pkt_count - 1'b1;

    if (inc_pipe[1] && !pkt_out)      rel_next = rel_count + 1'b1;
    else if (!inc_pipe[1] && pkt_out) rel_next = rel_count - 1'b1;

    // Full with no complete packet would deadlock: stream the packet out.
    if (pkt_out)                                        ct_next = 1'b0;
    else if (fill_level == FILL_MAX && pkt_count == '0) ct_next = 1'b1;

    if (rd_en)         q_valid_next = 1'b1;
    else if (load_out) q_valid_next = 1'b0;

    if (load_out) out_valid_next = 1'b1;
    else if (pop) out_valid_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_valid     <= 1'b0;
      out_valid   <= 1'b0;
      out_beat    <= '0;
      rel_count   <= '0;
      inc_pipe    <= '0;
      fill_level  <= '0;
      pkt_count   <= '0;
      cut_through <= 1'b0;
      s_tready    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)  rd_ptr <= rd_ptr + 1'b1;
      if (load_out) out_beat <= ram_rdata;
      q_valid     <= q_valid_next;
      out_valid   <= out_valid_next;
      rel_count   <= rel_next;
      inc_pipe    <= {inc_pipe[0], pkt_in};
      fill_level  <= fill_next;
      pkt_count   <= pkt_next;
      cut_through <= ct_next;
      s_tready    <= (fill_next < FILL_MAX) && (pkt_next < PKT_MAX);
    end
  end

endmodule

// File: tb/tb_ofs_fim_axis_pkt_buffer.sv
// Bench for ofs_fim_axis_pkt_buffer: a full-size instance for ordering, timing
// and packet-count limits, and a depth-8 instance for oversize cut-through.
module tb_ofs_fim_axis_pkt_buffer;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 4;
  localparam int BW = DW + KW + 1 + UW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          m_tvalid, m_tready = 1'b0, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic [6:0]    fill_level;
  logic [4:0]    pkt_count;
  logic          cut_through;

  // small instance
  logic          sm_s_tvalid = 1'b0, sm_s_tready, sm_s_tlast = 1'b0;
  logic [DW-1:0] sm_s_tdata = '0;
  logic [KW-1:0] sm_s_tkeep = '0;
  logic [UW-1:0] sm_s_tuser = '0;
  logic          sm_m_tvalid, sm_m_tready = 1'b0, sm_m_tlast;
  logic [DW-1:0] sm_m_tdata;
  logic [KW-1:0] sm_m_tkeep;
  logic [UW-1:0] sm_m_tuser;
  logic [3:0]    sm_fill;
  logic [4:0]    sm_pkt;
  logic          sm_cut;

  ofs_fim_axis_pkt_buffer #(
    .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DEPTH_LOG2(6), .MAX_PKTS_LOG2(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .fill_level(fill_level), .pkt_count(pkt_count), .cut_through(cut_through)
  );

  ofs_fim_axis_pkt_buffer #(
    .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DEPTH_LOG2(3), .MAX_PKTS_LOG2(4)
  ) dut_small (
    .clk(clk), .rst(rst),
    .s_tvalid(sm_s_tvalid), .s_tready(sm_s_tready), .s_tdata(sm_s_tdata),
    .s_tkeep(sm_s_tkeep), .s_tlast(sm_s_tlast), .s_tuser(sm_s_tuser),
    .m_tvalid(sm_m_tvalid), .m_tready(sm_m_tready), .m_tdata(sm_m_tdata),
    .m_tkeep(sm_m_tkeep), .m_tlast(sm_m_tlast), .m_tuser(sm_m_tuser),
    .fill_level(sm_fill), .pkt_count(sm_pkt), .cut_through(sm_cut)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboards: pushed on sink accept, popped on source handshake
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] sm_exp_q[$];
  int pop_total = 0, first_pop_cyc = -1, last_pop_cyc = -1;
  int sm_pops = 0;
  logic sm_ct_seen = 1'b0, sm_ct_prev = 1'b0;
  logic [3:0] sm_ct_fill = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (s_tvalid && s_tready) exp_q.push_back({s_tdata, s_tkeep, s_tlast, s_tuser});
      if (m_tvalid && m_tready) begin
        pop_total++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) check_val("unexpected_beat", 1, 0);
        else check_val("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (sm_s_tvalid && sm_s_tready) sm_exp_q.push_back({sm_s_tdata, sm_s_tkeep, sm_s_tlast, sm_s_tuser});
      if (sm_cut && !sm_ct_prev && !sm_ct_seen) begin
        sm_ct_seen = 1'b1;
        sm_ct_fill = sm_fill;
      end
      sm_ct_prev = sm_cut;
      if (sm_m_tvalid && sm_m_tready) begin
        sm_pops++;
        if (sm_m_tlast) check_val("ct_held_to_tlast", sm_cut, 1);
        if (sm_exp_q.size() == 0) check_val("sm_unexpected_beat", 1, 0);
        else check_val("sm_beat", {sm_m_tdata, sm_m_tkeep, sm_m_tlast, sm_m_tuser}, sm_exp_q.pop_front());
      end
    end
  end

  // Drivers: entered and left just after a rising edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int n = 0;
    logic acc = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    s_tkeep = KW'($urandom_range(0, 15));
    s_tuser = UW'($urandom_range(0, 15));
    while (!acc && n < 200) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1; n++;
    end
    s_tvalid = 1'b0;
    if (!acc) check_val("send_timeout", 0, 1);
  endtask

  task automatic sm_send_beat(input logic [DW-1:0] d, input logic last);
    int n = 0;
    logic acc = 1'b0;
    sm_s_tvalid = 1'b1; sm_s_tdata = d; sm_s_tlast = last;
    sm_s_tkeep = KW'($urandom_range(0, 15));
    sm_s_tuser = UW'($urandom_range(0, 15));
    while (!acc && n < 200) begin
      @(negedge clk); acc = sm_s_tready;
      @(posedge clk); #1; n++;
    end
    sm_s_tvalid = 1'b0;
    if (!acc) check_val("sm_send_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    check_val(tag, exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    int run, n, pops_before;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_s_tready", s_tready, 0);
    check_val("rst_m_tvalid", m_tvalid, 0);
    check_val("rst_m_tlast", m_tlast, 0);
    check_val("rst_m_tdata", m_tdata, 0);
    check_val("rst_fill", fill_level, 0);
    check_val("rst_pkt", pkt_count, 0);
    check_val("rst_cut", cut_through, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("s_tready_up", s_tready, 1);
    @(posedge clk); #1;

    // single 1-beat packet: release two cycles after accept
    m_tready = 1'b1;
    check_val("single_pkt_before", pkt_count, 0);
    send_beat(32'hA5, 1'b1);
    @(negedge clk);
    check_val("single_pkt_after_accept", pkt_count, 1);
    check_val("single_valid_t1", m_tvalid, 0);
    @(negedge clk);
    check_val("single_valid_t2", m_tvalid, 0);
    @(negedge clk);
    check_val("single_valid_t3", m_tvalid, 1);
    check_val("single_tdata", m_tdata, 32'hA5);
    check_val("single_tlast", m_tlast, 1);
    @(negedge clk);
    check_val("single_pkt_after_pop", pkt_count, 0);
    check_val("single_valid_done", m_tvalid, 0);
    @(posedge clk); #1;

    // hold until tlast, then four gap-free beats
    early = 1'b0;
    for (int b = 0; b < 3; b++) send_beat($urandom(), 1'b0);
    repeat (5) begin @(negedge clk); early |= m_tvalid; end
    @(posedge clk); #1;
    send_beat($urandom(), 1'b1);
    @(negedge clk); early |= m_tvalid;
    @(negedge clk); early |= m_tvalid;
    check_val("hold_early", early, 0);
    @(negedge clk);
    check_val("hold_release", m_tvalid, 1);
    run = 1;
    repeat (3) begin @(negedge clk); run += int'(m_tvalid); end
    check_val("hold_run", run, 4);
    @(negedge clk);
    check_val("hold_end", m_tvalid, 0);
    @(posedge clk); #1;

    // back-to-back stream: 16 packets of 3 beats
    pop_total = 0; first_pop_cyc = -1; last_pop_cyc = -1;
    for (int p = 0; p < 16; p++)
      for (int b = 0; b < 3; b++) send_beat($urandom(), b == 2);
    drain("stream_drain");
    check_val("stream_pops", pop_total, 48);
    check_val("stream_gapfree", last_pop_cyc - first_pop_cyc, 47);
    check_val("stream_fill", fill_level, 0);
    check_val("stream_pkt", pkt_count, 0);
    @(posedge clk); #1;

    // packet-count limit
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_beat($urandom(), 1'b1);
    @(negedge clk);
    check_val("limit_ready_low", s_tready, 0);
    check_val("limit_pkt16", pkt_count, 16);
    check_val("limit_fill16", fill_level, 16);
    @(posedge clk); #1;
    s_tvalid = 1'b1; s_tdata = 32'hDEAD_0017; s_tlast = 1'b1;
    s_tkeep = KW'($urandom_range(0, 15)); s_tuser = UW'($urandom_range(0, 15));
    m_tready = 1'b1;
    @(negedge clk);
    check_val("limit_blocked", s_tready, 0);
    check_val("limit_valid", m_tvalid, 1);
    @(posedge clk); #1; m_tready = 1'b0;
    @(negedge clk);
    check_val("limit_reopen", s_tready, 1);
    check_val("limit_pkt15", pkt_count, 15);
    @(posedge clk); #1; s_tvalid = 1'b0;
    @(negedge clk);
    check_val("limit_refull", s_tready, 0);
    check_val("limit_pkt_again", pkt_count, 16);
    @(posedge clk); #1; m_tready = 1'b1;
    drain("limit_drain");
    check_val("limit_fill_end", fill_level, 0);
    check_val("limit_pkt_end", pkt_count, 0);
    @(posedge clk); #1;

    // oversize packet through the depth-8 instance
    sm_m_tready = 1'b1;
    for (int i = 0; i < 12; i++) sm_send_beat(32'h100 + i, i == 11);
    n = 0;
    while (sm_exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check_val("ct_drain", sm_exp_q.size(), 0);
    @(negedge clk);
    check_val("ct_seen", sm_ct_seen, 1);
    check_val("ct_fill_at_set", sm_ct_fill, 8);
    check_val("ct_pops", sm_pops, 12);
    check_val("ct_cleared", sm_cut, 0);
    check_val("ct_fill_end", sm_fill, 0);
    @(posedge clk); #1;

    // reset with a released packet resident
    m_tready = 1'b0;
    for (int b = 0; b < 5; b++) send_beat($urandom(), b == 4);
    n = 0;
    while (!m_tvalid && n < 20) begin @(negedge clk); n++; end
    check_val("rst_mid_valid", m_tvalid, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; exp_q.delete();
    @(negedge clk);
    check_val("rst_mid_m_tvalid", m_tvalid, 0);
    check_val("rst_mid_s_tready", s_tready, 0);
    check_val("rst_mid_fill", fill_level, 0);
    check_val("rst_mid_pkt", pkt_count, 0);
    @(posedge clk); #1; rst = 1'b0; m_tready = 1'b1;
    pops_before = pop_total;
    repeat (20) @(negedge clk);
    check_val("rst_mid_no_stale", pop_total - pops_before, 0);
    @(posedge clk); #1;
    send_beat(32'h1234_5678, 1'b0);
    send_beat(32'h9ABC_DEF0, 1'b1);
    drain("post_rst_drain");
    check_val("post_rst_fill", fill_level, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/ofs_fim_axis_pkt_buffer.md
Name: ofs_fim_axis_pkt_buffer

Overview:
Store-and-forward AXI-S packet buffer on the PCIe SS TX/RX datapath. It sits directly downstream of the AXIS pipeline register chain. It accepts beats from that chain and releases a packet on the master side only once its tlast beat has been stored. This guarantees the consumer (e.g. arbiter or mux) never sees a mid-packet bubble caused by the producer.

Parameters:
TDATA_WIDTH, ofs_pcie_ss_cfg_pkg::TDATA_WIDTH, tdata width; tkeep width is TDATA_WIDTH/8.
TUSER_WIDTH, ofs_pcie_ss_cfg_pkg::TUSER_WIDTH, tuser_vendor width.
DEPTH_LOG2, 6, beat storage is 2**DEPTH_LOG2 entries.
MAX_PKTS_LOG2, 4, maximum of 2**MAX_PKTS_LOG2 complete packets resident.

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  synchronous active-high reset.
s_tvalid  in  1  sink beat valid.
s_tready  out  1  sink ready.
s_tdata  in  TDATA_WIDTH  sink data.
s_tkeep  in  TDATA_WIDTH/8  sink byte enables.
s_tlast  in  1  sink end of packet.
s_tuser  in  TUSER_WIDTH  sink tuser_vendor.
m_tvalid  out  1  source valid.
m_tready  in  1  source ready.
m_tdata  out  TDATA_WIDTH  source data.
m_tkeep  out  TDATA_WIDTH/8  source byte enables.
m_tlast  out  1  source end of packet.
m_tuser  out  TUSER_WIDTH  source tuser_vendor.
fill_level  out  DEPTH_LOG2+1  beats currently stored, including the output register.
pkt_count  out  MAX_PKTS_LOG2+1  complete packets stored.
cut_through  out  1  high while in oversize cut-through mode.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state is cleared on the clk edge where rst=1.
- Reset values: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata/m_tkeep/m_tuser=0, fill_level=0, pkt_count=0, cut_through=0. s_tready rises on the first cycle after rst deasserts.
- Sink accept: a beat is accepted when s_tvalid&s_tready.
  - s_tready = (fill_level < 2**DEPTH_LOG2) && (pkt_count < 2**MAX_PKTS_LOG2).
  - s_tready is registered and does not depend combinationally on s_tvalid.
- Storage: each beat is stored as {tdata,tkeep,tlast,tuser} in a simple dual-port RAM with a 1-cycle registered read. A prefetch output register feeds the m_* outputs.
- pkt_count:
  - +1 when an accepted beat has tlast=1.
  - -1 when a beat with m_tlast=1 is consumed (m_tvalid&m_tready).
  - Both in the same cycle: unchanged.
- Release rule: m_tvalid is asserted only when the output register holds a beat and (pkt_count>0 or cut_through=1).
  - Once asserted, m_tvalid stays high until the handshake completes.
  - m_* are stable while m_tvalid&!m_tready.
- Latency: into an empty buffer, if the tlast beat of a packet is accepted on edge T, m_tvalid is high in the cycle after edge T+2. For a 1-beat packet, latency is exactly 2 cycles.
- Throughput: sustains 1 beat/cycle in and 1 beat/cycle out simultaneously, with no bubbles between back-to-back stored packets.
- Oversize packet: if fill_level reaches 2**DEPTH_LOG2 with pkt_count==0:
  - cut_through is set and beats drain as stored, so a packet longer than the buffer cannot deadlock.
  - cut_through clears on the edge the tlast beat is consumed at the source.
- Full boundary: with fill_level == 2**DEPTH_LOG2, a simultaneous source pop reopens s_tready on the next cycle, not the same cycle.
- Wrap-around: read and write pointers are DEPTH_LOG2+1 bits; the MSB distinguishes full from empty.
- Reset mid-packet: stored and partial beats are discarded and nothing is emitted afterwards. Upstream is reset by the same signal.
- tkeep and tuser are passed through unmodified. No packet validation or dropping is performed.

Decomposition:
- No new package. Widths default from ofs_pcie_ss_cfg_pkg. Beat packing widths are local constants.
- Sub-module ofs_fim_axis_pkt_buffer_ram: parameterised simple dual-port RAM (WIDTH, DEPTH_LOG2), 1-cycle registered read, no reset on contents.
- Pointer, counter, cut-through and prefetch logic stay in the top module.

Test Plan:
- Single packet: reset, then 1-beat packet tdata=0xA5, tlast=1 accepted at cycle 10, m_tready=1 -> m_tvalid high in cycle 12, m_tdata=0xA5, m_tlast=1; pkt_count goes 0->1->0.
- Hold until tlast: 4-beat packet sent with a 5-cycle gap before tlast -> m_tvalid stays 0 until 2 cycles after tlast is accepted, then 4 consecutive beats with no gaps.
- Back-to-back stream: 16 packets of 3 beats, s_tvalid and m_tready held at 1 -> source gap-free after the first release, order and data preserved, final fill_level=0.
- Packet-count limit: m_tready=0, send 17 one-beat packets with MAX_PKTS_LOG2=4 -> s_tready drops after 16 are stored; one pop reopens s_tready on the next cycle.
- Oversize: DEPTH_LOG2=3, 12-beat packet -> cut_through asserts when fill_level=8, all 12 beats delivered in order, cut_through clears after the tlast beat is consumed.
- Reset mid-operation: assert rst with 5 beats stored and m_tvalid=1 -> next cycle m_tvalid=0, s_tready=0, fill_level=0, pkt_count=0; no stale beats appear after release.
